// File: rtl/nabp_filtered_ram_swap_control.sv
// Ping-pong controller for the two filtered-RAM line banks (filter writes, NABP reader consumes).
// Optional build macro NABP_FR_STALL_COUNT_EN adds o_stall_cycles (starved-request cycle counter).
//
// state | meaning
// IDLE  | waiting for i_start, no writes or grants
// RUN   | filling free banks and granting full banks to the reader
// DRAIN | all angles handed out, waiting for i_pr_done to free the last bank
module nabp_filtered_ram_swap_control #(
  parameter int ANGLE_LENGTH = 8,
  parameter int NO_OF_ANGLES = 180,
  parameter int ANGLE_STEP   = 1,
  parameter int LINE_LEN     = 256,
  parameter int ADDR_LENGTH  = 8,
  parameter int DATA_LENGTH  = 16
) (
  input  logic                           i_clk,
  input  logic                           i_reset_n,
  input  logic                           i_start,
  input  logic                           i_pr_done,
  input  logic                           i_fl_val_valid,
  input  logic signed [DATA_LENGTH-1:0]  i_fl_val,
  output logic                           o_fl_ready,
  output logic [1:0]                     o_ram_we,
  output logic [ADDR_LENGTH-1:0]         o_ram_waddr,
  output logic signed [DATA_LENGTH-1:0]  o_ram_wdata,
  output logic                           o_ram_rd_bank,
  output logic [ANGLE_LENGTH-1:0]        o_fr_angle,
  output logic                           o_fr_has_next_angle,
  input  logic                           i_fr_next_angle,
  output logic                           o_fr_next_angle_ack,
  output logic                           o_done
`ifdef NABP_FR_STALL_COUNT_EN
  ,
  output logic [15:0]                    o_stall_cycles
`endif
);

  localparam int                      CNT_W     = $clog2(NO_OF_ANGLES + 1);
  localparam logic [ADDR_LENGTH-1:0]  LAST_ADDR = ADDR_LENGTH'(LINE_LEN - 1);
  localparam logic [CNT_W-1:0]        N_ANG     = CNT_W'(NO_OF_ANGLES);
  localparam logic [CNT_W-1:0]        LAST_ANG  = CNT_W'(NO_OF_ANGLES - 1);
  localparam logic [ANGLE_LENGTH-1:0] STEP      = ANGLE_LENGTH'(ANGLE_STEP);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;
  typedef enum logic [1:0] {B_EMPTY, B_FILLING, B_FULL, B_READING} bank_t;

  state_t                  r_state;
  bank_t                   r_bank [2];
  logic [ANGLE_LENGTH-1:0] r_tag [2];
  logic [1:0]              r_full_q;
  logic                    r_wr_bank;
  logic                    r_rd_bank;
  logic                    r_first;
  logic [ADDR_LENGTH-1:0]  r_waddr;
  logic [ANGLE_LENGTH-1:0] r_fill_angle;
  logic [ANGLE_LENGTH-1:0] r_fr_angle;
  logic [CNT_W-1:0]        r_fills;
  logic [CNT_W-1:0]        r_delivered;

  logic w_active;
  logic w_fl_ready;
  logic w_wr;
  logic w_nb;
  logic w_ack;
  logic w_last_ack;
  logic w_done;

  assign w_active   = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign w_fl_ready = w_active && (r_fills < N_ANG) &&
                      ((r_bank[r_wr_bank] == B_EMPTY) || (r_bank[r_wr_bank] == B_FILLING));
  assign w_wr       = i_fl_val_valid && w_fl_ready;
  assign w_nb       = r_first ? 1'b0 : ~r_rd_bank;
  // r_full_q delays grantability by one cycle after a bank turns FULL
  assign w_ack      = (r_state == S_RUN) && i_fr_next_angle &&
                      (r_bank[w_nb] == B_FULL) && r_full_q[w_nb];
  assign w_last_ack = w_ack && (r_delivered == LAST_ANG);
  assign w_done     = (r_state == S_DRAIN) && i_pr_done;

  assign o_fl_ready          = w_fl_ready;
  assign o_ram_we            = w_wr ? (r_wr_bank ? 2'b10 : 2'b01) : 2'b00;
  assign o_ram_waddr         = r_waddr;
  assign o_ram_wdata         = i_fl_val;
  assign o_ram_rd_bank       = r_rd_bank;
  assign o_fr_angle          = r_fr_angle;
  assign o_fr_has_next_angle = (r_state == S_RUN) && (r_delivered < N_ANG);
  assign o_fr_next_angle_ack = w_ack;
  assign o_done              = w_done;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state <= S_IDLE;
      for (int b = 0; b < 2; b++) begin
        r_bank[b] <= B_EMPTY;
        r_tag[b]  <= '0;
      end
      r_full_q     <= '0;
      r_wr_bank    <= 1'b0;
      r_rd_bank    <= 1'b0;
      r_first      <= 1'b1;
      r_waddr      <= '0;
      r_fill_angle <= '0;
      r_fr_angle   <= '0;
      r_fills      <= '0;
      r_delivered  <= '0;
    end else begin
      r_full_q <= {r_bank[1] == B_FULL, r_bank[0] == B_FULL};
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_state <= S_RUN;
            for (int b = 0; b < 2; b++) r_bank[b] <= B_EMPTY;
            r_full_q     <= '0;
            r_wr_bank    <= 1'b0;
            r_first      <= 1'b1;
            r_waddr      <= '0;
            r_fill_angle <= '0;
            r_fills      <= '0;
            r_delivered  <= '0;
          end
        end
        S_RUN: begin
          if (w_last_ack) r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (i_pr_done) begin
            r_state <= S_IDLE;
            for (int b = 0; b < 2; b++)
              if (r_bank[b] == B_READING) r_bank[b] <= B_EMPTY;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_wr) begin
        if (r_waddr == LAST_ADDR) begin
          r_bank[r_wr_bank] <= B_FULL;
          r_tag[r_wr_bank]  <= r_fill_angle;
          r_fill_angle      <= r_fill_angle + STEP;
          r_fills           <= r_fills + 1'b1;
          r_waddr           <= '0;
          r_wr_bank         <= ~r_wr_bank;
        end else begin
          r_bank[r_wr_bank] <= B_FILLING;
          r_waddr           <= r_waddr + 1'b1;
        end
      end

      // the write bank is never READING, so a release cannot collide with a write
      if (w_ack) begin
        r_bank[w_nb] <= B_READING;
        if (r_bank[~w_nb] == B_READING) r_bank[~w_nb] <= B_EMPTY;
        r_rd_bank   <= w_nb;
        r_fr_angle  <= r_tag[w_nb];
        r_delivered <= r_delivered + 1'b1;
        r_first     <= 1'b0;
      end
    end
  end

`ifdef NABP_FR_STALL_COUNT_EN
  logic [15:0] r_stall_cycles;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_stall_cycles <= '0;
    end else if ((r_state == S_IDLE) && i_start) begin
      r_stall_cycles <= '0;
    end else if ((r_state == S_RUN) && i_fr_next_angle && !w_ack &&
                 (r_stall_cycles != 16'hFFFF)) begin
      r_stall_cycles <= r_stall_cycles + 16'd1;
    end
  end

  assign o_stall_cycles = r_stall_cycles;
`endif

endmodule

// File: tb/tb_nabp_filtered_ram_swap_control.sv
// Directed bench for nabp_filtered_ram_swap_control with NO_OF_ANGLES=4, LINE_LEN=8.
// Build with NABP_FR_STALL_COUNT_EN defined to also exercise o_stall_cycles.
module tb_nabp_filtered_ram_swap_control;
  localparam int AL = 8;
  localparam int NA = 4;
  localparam int LL = 8;
  localparam int AW = 3;
  localparam int DW = 16;

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic                 start;
  logic                 pr_done;
  logic                 fl_val_valid;
  logic signed [DW-1:0] fl_val;
  logic                 fl_ready;
  logic [1:0]           ram_we;
  logic [AW-1:0]        ram_waddr;
  logic signed [DW-1:0] ram_wdata;
  logic                 ram_rd_bank;
  logic [AL-1:0]        fr_angle;
  logic                 fr_has_next_angle;
  logic                 fr_next_angle;
  logic                 fr_next_angle_ack;
  logic                 done;
`ifdef NABP_FR_STALL_COUNT_EN
  logic [15:0]          stall_cycles;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nabp_filtered_ram_swap_control #(
    .ANGLE_LENGTH(AL), .NO_OF_ANGLES(NA), .ANGLE_STEP(1),
    .LINE_LEN(LL), .ADDR_LENGTH(AW), .DATA_LENGTH(DW)
  ) dut (
    .i_clk(clk),
    .i_reset_n(reset_n),
    .i_start(start),
    .i_pr_done(pr_done),
    .i_fl_val_valid(fl_val_valid),
    .i_fl_val(fl_val),
    .o_fl_ready(fl_ready),
    .o_ram_we(ram_we),
    .o_ram_waddr(ram_waddr),
    .o_ram_wdata(ram_wdata),
    .o_ram_rd_bank(ram_rd_bank),
    .o_fr_angle(fr_angle),
    .o_fr_has_next_angle(fr_has_next_angle),
    .i_fr_next_angle(fr_next_angle),
    .o_fr_next_angle_ack(fr_next_angle_ack),
    .o_done(done)
`ifdef NABP_FR_STALL_COUNT_EN
    ,
    .o_stall_cycles(stall_cycles)
`endif
  );

  // inputs change 1 time unit after the rising edge; checks happen 1 unit later
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0; start = 1'b0; pr_done = 1'b0;
    fl_val_valid = 1'b0; fl_val = '0; fr_next_angle = 1'b0;
    next_cycle();
    reset_n = 1'b1;
    next_cycle();
  endtask

  // leaves the bench in cycle 1, the first RUN cycle
  task automatic start_run();
    start = 1'b1;
    next_cycle();
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; pr_done = 1'b0;
    fl_val_valid = 1'b1; fl_val = '0; fr_next_angle = 1'b1;
    next_cycle();
    next_cycle();
    #1;
    checks++;
    if (fl_ready !== 1'b0) begin
      errors++; $display("FAIL reset_fl_ready: got %0h want 0", fl_ready);
    end
    checks++;
    if (ram_we !== 2'b00 || ram_waddr !== '0 || ram_wdata !== '0) begin
      errors++; $display("FAIL reset_ram: we=%0h waddr=%0h wdata=%0h want 0", ram_we, ram_waddr, ram_wdata);
    end
    checks++;
    if (ram_rd_bank !== 1'b0 || fr_angle !== '0) begin
      errors++; $display("FAIL reset_read: bank=%0h angle=%0h want 0", ram_rd_bank, fr_angle);
    end
    checks++;
    if (fr_has_next_angle !== 1'b0 || fr_next_angle_ack !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL reset_ctrl: has_next=%0h ack=%0h done=%0h want 0", fr_has_next_angle, fr_next_angle_ack, done);
    end
    reset_n = 1'b1; fl_val_valid = 1'b0; fr_next_angle = 1'b0;
    next_cycle();
  endtask

  task automatic test_mid_fill_reset();
    start_run();
    for (int c = 1; c <= 6; c++) begin
      fl_val_valid = 1'b1; fl_val = DW'(c);
      #1;
      checks++;
      if (ram_we !== 2'b01 || ram_waddr !== AW'(c - 1) || fl_ready !== 1'b1) begin
        errors++; $display("FAIL midfill_write c=%0d: we=%0h waddr=%0h ready=%0h want 1 %0h 1", c, ram_we, ram_waddr, fl_ready, c - 1);
      end
      if (c == 6) reset_n = 1'b0;
      next_cycle();
    end
    #1;
    checks++;
    if (fl_ready !== 1'b0 || ram_we !== 2'b00 || ram_waddr !== '0) begin
      errors++; $display("FAIL midfill_reset: ready=%0h we=%0h waddr=%0h want 0 0 0", fl_ready, ram_we, ram_waddr);
    end
    reset_n = 1'b1; fl_val_valid = 1'b0;
    next_cycle();
  endtask

  // reader takes angle0 then stops; writer fills bank1 and stalls until the next grant
  task automatic test_writer_blocked();
    logic [1:0] exp_we;
    logic       exp_ack;
    start_run();
    for (int c = 1; c <= 30; c++) begin
      fl_val_valid  = 1'b1;
      fl_val        = DW'(16'h0100 + c);
      fr_next_angle = (c <= 10) || (c >= 26);
      pr_done       = (c == 20);
      #1;
      if (c <= 8)       exp_we = 2'b01;
      else if (c <= 16) exp_we = 2'b10;
      else if (c >= 27) exp_we = 2'b01;
      else              exp_we = 2'b00;
      exp_ack = (c == 10) || (c == 26);
      checks++;
      if (ram_we !== exp_we || fl_ready !== (exp_we != 2'b00)) begin
        errors++; $display("FAIL blocked_write c=%0d: we=%0h ready=%0h want we=%0h", c, ram_we, fl_ready, exp_we);
      end
      checks++;
      if (fr_next_angle_ack !== exp_ack || done !== 1'b0) begin
        errors++; $display("FAIL blocked_ack c=%0d: ack=%0h done=%0h want ack=%0h done=0", c, fr_next_angle_ack, done, exp_ack);
      end
      if (c >= 11) begin
        checks++;
        if (fr_angle !== AL'(c >= 27 ? 1 : 0) || ram_rd_bank !== (c >= 27)) begin
          errors++; $display("FAIL blocked_angle c=%0d: angle=%0h bank=%0h want %0h %0h", c, fr_angle, ram_rd_bank, (c >= 27 ? 1 : 0), (c >= 27 ? 1 : 0));
        end
      end
      next_cycle();
    end
    pr_done = 1'b0;
  endtask

  // continuous writer, reader requesting from start: grants at cycles 10, 18, 28, 38
  task automatic test_nominal();
    logic [1:0]    exp_we;
    logic [AW-1:0] exp_waddr;
    logic          exp_ack;
    int            exp_ang;
    int            done_cnt;
    done_cnt = 0;
    start_run();
    for (int c = 1; c <= 45; c++) begin
      fl_val_valid  = 1'b1;
      fl_val        = DW'(c * 3 - 100);
      fr_next_angle = 1'b1;
      #1;
      exp_waddr = '0;
      if (c <= 8)                begin exp_we = 2'b01; exp_waddr = AW'(c - 1);  end
      else if (c <= 16)          begin exp_we = 2'b10; exp_waddr = AW'(c - 9);  end
      else if (c >= 19 && c <= 26) begin exp_we = 2'b01; exp_waddr = AW'(c - 19); end
      else if (c >= 29 && c <= 36) begin exp_we = 2'b10; exp_waddr = AW'(c - 29); end
      else                         exp_we = 2'b00;
      exp_ack = (c == 10) || (c == 18) || (c == 28) || (c == 38);
      exp_ang = (c >= 39) ? 3 : (c >= 29) ? 2 : (c >= 19) ? 1 : 0;
      checks++;
      if (ram_we !== exp_we || fl_ready !== (exp_we != 2'b00) || ram_waddr !== exp_waddr) begin
        errors++; $display("FAIL nominal_write c=%0d: we=%0h ready=%0h waddr=%0h want we=%0h waddr=%0h", c, ram_we, fl_ready, ram_waddr, exp_we, exp_waddr);
      end
      if (exp_we != 2'b00) begin
        checks++;
        if (ram_wdata !== fl_val) begin
          errors++; $display("FAIL nominal_wdata c=%0d: got %0h want %0h", c, ram_wdata, fl_val);
        end
      end
      checks++;
      if (fr_next_angle_ack !== exp_ack || fr_has_next_angle !== (c <= 38)) begin
        errors++; $display("FAIL nominal_ack c=%0d: ack=%0h has_next=%0h want %0h %0h", c, fr_next_angle_ack, fr_has_next_angle, exp_ack, (c <= 38));
      end
      checks++;
      if (fr_angle !== AL'(exp_ang) || ram_rd_bank !== exp_ang[0]) begin
        errors++; $display("FAIL nominal_angle c=%0d: angle=%0h bank=%0h want %0h %0h", c, fr_angle, ram_rd_bank, exp_ang, exp_ang[0]);
      end
      if (done) done_cnt++;
      next_cycle();
    end
    checks++;
    if (done_cnt !== 0) begin
      errors++; $display("FAIL nominal_early_done: got %0d pulses want 0", done_cnt);
    end
  endtask

  // continues from the DRAIN state left by test_nominal
  task automatic test_last_angle();
    pr_done = 1'b1;
    #1;
    checks++;
    if (done !== 1'b1 || fr_next_angle_ack !== 1'b0) begin
      errors++; $display("FAIL last_done: done=%0h ack=%0h want 1 0", done, fr_next_angle_ack);
    end
    next_cycle();
    pr_done = 1'b0;
    #1;
    checks++;
    if (done !== 1'b0 || fr_has_next_angle !== 1'b0 || fl_ready !== 1'b0 || fr_angle !== AL'(3)) begin
      errors++; $display("FAIL last_idle: done=%0h has_next=%0h ready=%0h angle=%0h want 0 0 0 3", done, fr_has_next_angle, fl_ready, fr_angle);
    end
    pr_done = 1'b1;
    #1;
    checks++;
    if (done !== 1'b0 || fr_next_angle_ack !== 1'b0) begin
      errors++; $display("FAIL idle_pr_done: done=%0h ack=%0h want 0 0", done, fr_next_angle_ack);
    end
    next_cycle();
    pr_done = 1'b0; fl_val_valid = 1'b0; fr_next_angle = 1'b0;
  endtask

  task automatic test_stall();
`ifdef NABP_FR_STALL_COUNT_EN
    start_run();
    for (int c = 1; c <= 8; c++) begin
      fl_val_valid  = 1'b0;
      fr_next_angle = (c <= 5);
      #1;
      checks++;
      if (stall_cycles !== 16'(c <= 5 ? c - 1 : 5)) begin
        errors++; $display("FAIL stall_count c=%0d: got %0d want %0d", c, stall_cycles, (c <= 5 ? c - 1 : 5));
      end
      next_cycle();
    end
    fr_next_angle = 1'b0;
`endif
  endtask

  initial begin
    test_reset();
    test_mid_fill_reset();
    test_writer_blocked();
    apply_reset();
    test_nominal();
    test_last_angle();
    apply_reset();
    test_stall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
